// File: rtl/cond_sum_subtractor_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cond_sum_subtractor_pipe
// Purpose  : Two-stage pipelined conditional-sum subtractor on a valid/ready
//            stream. Computes diff = a - b - bin (mod 2^WIDTH), together with
//            an unsigned borrow-out and a signed-overflow flag.
//            Stage 1 resolves the low half and precomputes both high-half
//            candidates (low borrow 0 / low borrow 1). Stage 2 selects the
//            high-half candidate using the registered low-half borrow.
// Ports    : clk        rising-edge clock
//            rst        asynchronous reset, active low (0 = reset)
//            in_valid   operand beat offered
//            in_ready   block accepts a beat this cycle
//            a, b       minuend / subtrahend, WIDTH bits
//            bin        borrow-in
//            out_valid  result beat offered (registered)
//            out_ready  consumer accepts result
//            diff       (a - b - bin) mod 2^WIDTH (registered)
//            bout       1 iff a < b + bin (registered)
//            ovf        signed overflow of the subtraction (registered)
// Params   : WIDTH      operand width, even and >= 4
// Revision : 1.0  initial release
// ============================================================================
module cond_sum_subtractor_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int HALF = WIDTH / 2;
    localparam int MSB  = WIDTH - 1;

    // ------------------------------------------------------------------------
    // Ripple of full-adder cells over one half-word. Returns {carry_out, sum}.
    // Subtraction is realised as x + ~y + cin, so a carry out of 1 means
    // "no borrow".
    // ------------------------------------------------------------------------
    function automatic logic [HALF:0] ripple_add(
        input logic [HALF-1:0] x,
        input logic [HALF-1:0] y,
        input logic            cin
    );
        logic            c;
        logic [HALF-1:0] s;
        c = cin;
        s = '0;
        for (int i = 0; i < HALF; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    // ------------------------------------------------------------------------
    // Stage-1 combinational datapath
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_b_n;
    logic [HALF:0]    w_lo_sum;
    logic             w_lo_borrow;
    logic [HALF:0]    w_hi0_sum;     // high half assuming low borrow = 0
    logic [HALF:0]    w_hi1_sum;     // high half assuming low borrow = 1
    logic             w_hi0_bout;
    logic             w_hi1_bout;
    logic             w_hi0_ovf;
    logic             w_hi1_ovf;
    logic             w_sign_differs;

    assign w_b_n = ~b;

    // Carry-in of the low half is the inverse of the borrow-in.
    assign w_lo_sum    = ripple_add(a[HALF-1:0], w_b_n[HALF-1:0], ~bin);
    assign w_lo_borrow = ~w_lo_sum[HALF];

    // A low-half borrow of 0 is a carry of 1 into the high half, and vice versa.
    assign w_hi0_sum = ripple_add(a[MSB:HALF], w_b_n[MSB:HALF], 1'b1);
    assign w_hi1_sum = ripple_add(a[MSB:HALF], w_b_n[MSB:HALF], 1'b0);

    assign w_hi0_bout = ~w_hi0_sum[HALF];
    assign w_hi1_bout = ~w_hi1_sum[HALF];

    // Signed overflow only possible when operand signs differ; it occurs when
    // the result sign departs from the minuend sign.
    assign w_sign_differs = a[MSB] ^ b[MSB];
    assign w_hi0_ovf      = w_sign_differs & (w_hi0_sum[HALF-1] ^ a[MSB]);
    assign w_hi1_ovf      = w_sign_differs & (w_hi1_sum[HALF-1] ^ a[MSB]);

    // ------------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------------
    logic            s1_valid_q,     s1_valid_d;
    logic [HALF-1:0] s1_lo_diff_q,   s1_lo_diff_d;
    logic            s1_lo_borrow_q, s1_lo_borrow_d;
    logic [HALF-1:0] s1_hi0_q,       s1_hi0_d;
    logic            s1_bout0_q,     s1_bout0_d;
    logic            s1_ovf0_q,      s1_ovf0_d;
    logic [HALF-1:0] s1_hi1_q,       s1_hi1_d;
    logic            s1_bout1_q,     s1_bout1_d;
    logic            s1_ovf1_q,      s1_ovf1_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] diff_q,      diff_d;
    logic             bout_q,      bout_d;
    logic             ovf_q,       ovf_d;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    logic w_s2_free;
    logic w_accept;
    logic w_s1_advance;

    // Stage 2 can take a new beat if empty or being drained this cycle.
    assign w_s2_free    = ~out_valid_q | out_ready;
    // No dependence on in_valid, so upstream may wait on in_ready safely.
    assign in_ready     = ~s1_valid_q | w_s2_free;
    assign w_accept     = in_valid & in_ready;
    assign w_s1_advance = s1_valid_q & w_s2_free;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        s1_valid_d     = s1_valid_q;
        s1_lo_diff_d   = s1_lo_diff_q;
        s1_lo_borrow_d = s1_lo_borrow_q;
        s1_hi0_d       = s1_hi0_q;
        s1_bout0_d     = s1_bout0_q;
        s1_ovf0_d      = s1_ovf0_q;
        s1_hi1_d       = s1_hi1_q;
        s1_bout1_d     = s1_bout1_q;
        s1_ovf1_d      = s1_ovf1_q;
        out_valid_d    = out_valid_q;
        diff_d         = diff_q;
        bout_d         = bout_q;
        ovf_d          = ovf_q;

        // Stage 1: a new accept overrides the departure of the previous beat,
        // which lets advance and accept happen in the same cycle.
        if (w_accept) begin
            s1_valid_d     = 1'b1;
            s1_lo_diff_d   = w_lo_sum[HALF-1:0];
            s1_lo_borrow_d = w_lo_borrow;
            s1_hi0_d       = w_hi0_sum[HALF-1:0];
            s1_bout0_d     = w_hi0_bout;
            s1_ovf0_d      = w_hi0_ovf;
            s1_hi1_d       = w_hi1_sum[HALF-1:0];
            s1_bout1_d     = w_hi1_bout;
            s1_ovf1_d      = w_hi1_ovf;
        end else if (w_s1_advance) begin
            s1_valid_d = 1'b0;
        end

        // Stage 2: the conditional-sum select on the registered low borrow.
        // out_valid drops only when the consumer takes a beat and nothing
        // refills the stage.
        if (w_s1_advance) begin
            out_valid_d = 1'b1;
            if (s1_lo_borrow_q) begin
                diff_d = {s1_hi1_q, s1_lo_diff_q};
                bout_d = s1_bout1_q;
                ovf_d  = s1_ovf1_q;
            end else begin
                diff_d = {s1_hi0_q, s1_lo_diff_q};
                bout_d = s1_bout0_q;
                ovf_d  = s1_ovf0_q;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State registers; reset discards every in-flight beat.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q     <= 1'b0;
            s1_lo_diff_q   <= '0;
            s1_lo_borrow_q <= 1'b0;
            s1_hi0_q       <= '0;
            s1_bout0_q     <= 1'b0;
            s1_ovf0_q      <= 1'b0;
            s1_hi1_q       <= '0;
            s1_bout1_q     <= 1'b0;
            s1_ovf1_q      <= 1'b0;
            out_valid_q    <= 1'b0;
            diff_q         <= '0;
            bout_q         <= 1'b0;
            ovf_q          <= 1'b0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_lo_diff_q   <= s1_lo_diff_d;
            s1_lo_borrow_q <= s1_lo_borrow_d;
            s1_hi0_q       <= s1_hi0_d;
            s1_bout0_q     <= s1_bout0_d;
            s1_ovf0_q      <= s1_ovf0_d;
            s1_hi1_q       <= s1_hi1_d;
            s1_bout1_q     <= s1_bout1_d;
            s1_ovf1_q      <= s1_ovf1_d;
            out_valid_q    <= out_valid_d;
            diff_q         <= diff_d;
            bout_q         <= bout_d;
            ovf_q          <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: doc/cond_sum_subtractor_pipe.md
Name: cond_sum_subtractor_pipe

Overview:
- Two-stage pipelined conditional-sum subtractor: diff = a - b - bin, with borrow-out and signed-overflow flags.
- The inverse operation to the team's registered conditional-sum adder.
- Sits on a valid/ready stream so ALU and datapath blocks can apply backpressure.
- Stage 1 resolves the low half and precomputes both high-half candidates; stage 2 selects the high half on the low-half borrow.

Parameters:
- WIDTH, 8, operand width in bits; must be even and at least 4; low half = WIDTH/2 bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- in_valid  input  1  operand beat offered
- in_ready  output  1  block accepts beat this cycle
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  result beat offered
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  (a - b - bin) mod 2^WIDTH
- bout  output  1  unsigned borrow-out: 1 iff a < b + bin
- ovf  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB]

Behaviour:
Reset
- rst low asserts asynchronously and clears both stage valids, out_valid, diff, bout, ovf and all stage registers to 0.
- in_ready reads 1 the first cycle after reset releases.
- Reset mid-operation discards all in-flight beats; no result is emitted for them.

Arithmetic
- Subtraction is a + ~b + ~bin (carry-in = !bin); borrow = !carry.
- Low half L = WIDTH/2 bits, ripple of full-adder cells.
- High half is computed twice, assuming low borrow 0 and low borrow 1 (conditional sum).
- Each candidate yields its own high diff, bout and ovf.

Stage 1 register, loaded on accept (in_valid & in_ready):
- low diff, low borrow.
- Both high candidates with their bout/ovf bits.
- s1_valid.

Stage 2 register (output), loaded when s1_valid and stage 2 can accept:
- diff = {selected high, low}.
- bout and ovf taken from the candidate chosen by the stage-1 low borrow.
- out_valid = 1.

Handshake
- s2_free = !out_valid | out_ready.
- in_ready = !s1_valid | s2_free (combinational, no dependence on in_valid).
- A beat transfers on in_valid & in_ready; the result transfers on out_valid & out_ready.
- Latency: exactly 2 cycles from accept to out_valid with no backpressure.
- Throughput: 1 beat/cycle when out_ready is held high.
- Output data holds stable while out_valid & !out_ready; capacity is 2 beats.
- Simultaneous output drain and stage-1 advance in one cycle is legal and loses no beat.
- Simultaneous stage-1 advance and a new accept in one cycle is legal.
- out_valid falls only when a transfer occurs with no stage-1 beat advancing.
- Inputs are ignored when in_valid = 0; the outputs are registered only.

Test Plan:
- WIDTH=8: a=0x50, b=0x20, bin=0, out_ready=1 -> 2 cycles later diff=0x30, bout=0, ovf=0.
- Low-half borrow path: a=0x10, b=0x01, bin=1 -> diff=0x0E, bout=0, ovf=0; a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1, ovf=0 (wrap-around).
- Signed overflow: a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1; a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
- Backpressure: stream 4 beats with out_ready=0 -> in_ready drops after 2 accepts and output holds the first result stable. Then raise out_ready -> all 4 results delivered in order with no loss or duplication, then 1 result/cycle.
- Random streaming: 1000 random a/b/bin with random in_valid/out_ready -> every result matches the reference model, in order; WIDTH=16 regression also passes.
- Reset mid-stream: assert rst low with 2 beats in flight -> out_valid, diff, bout, ovf go to 0 immediately (asynchronously). After release, in_ready=1 and the next beat yields a correct result 2 cycles later.
